pipe_stall_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline registers (F/D, D/E, E/M, M/W) and the PC.
- Tracks multiply/divide unit occupancy with a busy counter FSM.
- Merges decode-stage data hazards with MD-use hazards into a single stall decision.
- Gives the CP0 exception request (Req) absolute priority. Emits the en/clear controls that every stage register consumes.

---
 rtl/pipe_stall_ctrl_pkg.sv | 16 +
 rtl/md_busy_fsm.sv | 67 ++++++
 rtl/pipe_stall_ctrl.sv | 89 ++++++++
 tb/tb_pipe_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
// Shared definitions for the pipeline stall controller:
//   - md_state_e      : multiply/divide occupancy FSM encoding (IDLE/BUSY)
//   - *_DEFAULT       : default MD latencies and busy-counter width
package pipe_stall_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;
  localparam int CNT_W_DEFAULT       = 4;

endpackage

// File: rtl/md_busy_fsm.sv
// md_busy_fsm
// Tracks occupancy of the multiply/divide unit.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   E_md_start   : E-stage instruction starts an MD op this cycle
//   E_md_div     : qualifies E_md_start (1 = div/divu, 0 = mult/multu)
//   Req          : exception request; squashes a start in the same cycle
//   md_busy      : MD unit occupied (combinational, includes start cycle)
//   md_start_ok  : gated start strobe to the MDU
module md_busy_fsm
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic E_md_start,
  input  logic E_md_div,
  input  logic Req,
  output logic md_busy,
  output logic md_start_ok
);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;

  // The instruction carrying a start is being flushed when Req is high,
  // so the MDU must not see that start.
  assign md_start_ok = E_md_start & ~Req;

  // The start cycle already counts as busy so a following MD-use
  // instruction in decode stalls without a one-cycle gap.
  assign md_busy = (state == BUSY) | md_start_ok;

  // A running op is never aborted by Req; HI/LO still commit. A start seen
  // while BUSY is ignored, so the counter is never reloaded mid-op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start_ok) begin
            state <= BUSY;
            cnt   <= E_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end
        end
        BUSY: begin
          if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Central sequencer for the PC and the F/D, D/E, E/M, M/W stage registers.
// Optional feature macro: STALL_CNT_EN (adds stall_cnt[31:0] output).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   D_hazard              : decode-stage unresolvable data hazard
//   D_md_use              : decode instruction uses the MD unit
//   E_md_start, E_md_div  : E-stage MD start and its div/mult qualifier
//   Req                   : CP0 exception/interrupt request (top priority)
//   PC_en, FD_en, DE_en,
//   EM_en, MW_en          : stage register / PC enables
//   DE_clear              : insert bubble into D/E
//   md_busy, md_start_ok  : MD occupancy and gated start strobe
//   stall_cnt             : (STALL_CNT_EN only) count of effective stall cycles
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        D_hazard,
  input  logic        D_md_use,
  input  logic        E_md_start,
  input  logic        E_md_div,
  input  logic        Req,
  output logic        PC_en,
  output logic        FD_en,
  output logic        DE_clear,
  output logic        DE_en,
  output logic        EM_en,
  output logic        MW_en,
  output logic        md_busy,
`ifdef STALL_CNT_EN
  output logic        md_start_ok,
  output logic [31:0] stall_cnt
`else
  output logic        md_start_ok
`endif
);

  logic stall;

  md_busy_fsm #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_fsm (
    .clk         (clk),
    .reset       (reset),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .Req         (Req),
    .md_busy     (md_busy),
    .md_start_ok (md_start_ok)
  );

  assign stall = D_hazard | (D_md_use & md_busy);

  // Req wins over stall: every register keeps moving so the stages can
  // flush themselves and the PC can load the handler address.
  always_comb begin
    PC_en    = 1'b1;
    FD_en    = 1'b1;
    DE_clear = 1'b0;
    DE_en    = 1'b1;
    EM_en    = 1'b1;
    MW_en    = 1'b1;
    if (!Req && stall) begin
      PC_en    = 1'b0;
      FD_en    = 1'b0;
      DE_clear = 1'b1;
    end
  end

`ifdef STALL_CNT_EN
  // Only stalls that actually hold the front end are counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !Req) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic reset, D_hazard, D_md_use, E_md_start, E_md_div, Req;
  logic PC_en, FD_en, DE_clear, DE_en, EM_en, MW_en, md_busy, md_start_ok;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // {PC_en, FD_en, DE_clear, DE_en, EM_en, MW_en}
  localparam logic [5:0] EN_RUN   = 6'b110111;
  localparam logic [5:0] EN_STALL = 6'b001111;

  logic [7:0] obs;
  assign obs = {PC_en, FD_en, DE_clear, DE_en, EM_en, MW_en, md_busy, md_start_ok};

  pipe_stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_hazard    (D_hazard),
    .D_md_use    (D_md_use),
    .E_md_start  (E_md_start),
    .E_md_div    (E_md_div),
    .Req         (Req),
    .PC_en       (PC_en),
    .FD_en       (FD_en),
    .DE_clear    (DE_clear),
    .DE_en       (DE_en),
    .EM_en       (EM_en),
    .MW_en       (MW_en),
    .md_busy     (md_busy),
`ifdef STALL_CNT_EN
    .md_start_ok (md_start_ok),
    .stall_cnt   (stall_cnt)
`else
    .md_start_ok (md_start_ok)
`endif
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge; outputs are then
  // sampled 1 time unit later, well away from the rising edge.
  task automatic cyc(input logic haz, input logic use_md, input logic st,
                     input logic dv, input logic rq);
    @(negedge clk);
    D_hazard   = haz;
    D_md_use   = use_md;
    E_md_start = st;
    E_md_div   = dv;
    Req        = rq;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; D_hazard = 0; D_md_use = 0; E_md_start = 0; E_md_div = 0; Req = 0;
    #2;
    tests++;
    if (obs !== {EN_RUN, 2'b00}) begin
      fails++; $display("FAIL reset_idle got=%b exp=%b", obs, {EN_RUN, 2'b00});
    end
    E_md_start = 1'b1;
    #1;
    tests++;
    if (md_start_ok !== 1'b1) begin
      fails++; $display("FAIL reset_start_ok got=%b exp=1", md_start_ok);
    end
    E_md_start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] reset: released");
  endtask

  task automatic test_mult_stall;
    logic [7:0] exp;
    cyc(0, 0, 1, 0, 0);
    tests++;
    if (obs !== {EN_RUN, 2'b11}) begin
      fails++; $display("FAIL mult_start got=%b exp=%b", obs, {EN_RUN, 2'b11});
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 1, 0, 0, 0);
      exp = (i <= 5) ? {EN_STALL, 2'b10} : {EN_RUN, 2'b00};
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL mult_stall t+%0d got=%b exp=%b", i, obs, exp);
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] mult: start + 5 busy cycles checked");
  endtask

  task automatic test_div_mfhi;
    logic [7:0] exp;
    cyc(0, 0, 1, 1, 0);
    tests++;
    if (obs !== {EN_RUN, 2'b11}) begin
      fails++; $display("FAIL div_start got=%b exp=%b", obs, {EN_RUN, 2'b11});
    end
    for (int i = 1; i <= 11; i++) begin
      cyc(0, (i >= 8) ? 1'b1 : 1'b0, 0, 0, 0);
      if (i <= 7)       exp = {EN_RUN, 2'b10};
      else if (i <= 10) exp = {EN_STALL, 2'b10};
      else              exp = {EN_RUN, 2'b00};
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL div_mfhi t+%0d got=%b exp=%b", i, obs, exp);
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] div: 11 busy cycles, mfhi stalls 8..10");
  endtask

  task automatic test_req_squash;
    cyc(0, 1, 1, 0, 1);
    tests++;
    if (obs !== {EN_RUN, 2'b00}) begin
      fails++; $display("FAIL req_squash got=%b exp=%b", obs, {EN_RUN, 2'b00});
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (obs !== {EN_RUN, 2'b00}) begin
      fails++; $display("FAIL req_squash_after got=%b exp=%b", obs, {EN_RUN, 2'b00});
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] req_squash: start dropped");
  endtask

  task automatic test_req_busy;
    logic [7:0] exp;
    cyc(0, 0, 1, 0, 0);              // mult start, cnt=5 next
    cyc(0, 0, 0, 0, 0);              // cnt=5
    cyc(0, 0, 0, 0, 0);              // cnt=4
    cyc(1, 1, 0, 0, 1);              // cnt=3, Req with hazard
    tests++;
    if (obs !== {EN_RUN, 2'b10}) begin
      fails++; $display("FAIL req_busy got=%b exp=%b", obs, {EN_RUN, 2'b10});
    end
    for (int i = 4; i <= 6; i++) begin
      cyc(0, 1, 0, 0, 0);
      exp = (i <= 5) ? {EN_STALL, 2'b10} : {EN_RUN, 2'b00};
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL req_busy_cont t+%0d got=%b exp=%b", i, obs, exp);
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] req_busy: op continues to completion");
  endtask

  task automatic test_hazard;
    cyc(1, 0, 0, 0, 0);
    tests++;
    if (obs !== {EN_STALL, 2'b00}) begin
      fails++; $display("FAIL hazard_only got=%b exp=%b", obs, {EN_STALL, 2'b00});
    end
    cyc(0, 1, 0, 0, 0);
    tests++;
    if (obs !== {EN_RUN, 2'b00}) begin
      fails++; $display("FAIL md_use_idle got=%b exp=%b", obs, {EN_RUN, 2'b00});
    end
    $display("[TB] hazard: plain data hazard stall");
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    cyc(0, 0, 1, 0, 0);              // mult start
    for (int i = 1; i <= 5; i++) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);              // div start right after IDLE return
    tests++;
    if (obs !== {EN_RUN, 2'b11}) begin
      fails++; $display("FAIL b2b_start got=%b exp=%b", obs, {EN_RUN, 2'b11});
    end
    for (int i = 1; i <= 11; i++) begin
      // Illegal mult start at i=8 must not reload the counter.
      cyc(0, 1, (i == 8) ? 1'b1 : 1'b0, 0, 0);
      exp = (i <= 10) ? {EN_STALL, 1'b1, (i == 8) ? 1'b1 : 1'b0} : {EN_RUN, 2'b00};
      tests++;
      if (obs !== exp) begin
        fails++; $display("FAIL b2b_div t+%0d got=%b exp=%b", i, obs, exp);
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] back_to_back: second op accepted, no reload");
  endtask

  task automatic test_reset_mid;
    cyc(0, 0, 1, 1, 0);              // div start
    cyc(0, 0, 0, 0, 0);              // cnt=10
    cyc(0, 0, 0, 0, 0);              // cnt=9
    cyc(0, 0, 0, 0, 0);              // cnt=8
    cyc(0, 1, 0, 0, 0);              // cnt=7
    tests++;
    if (obs !== {EN_STALL, 2'b10}) begin
      fails++; $display("FAIL pre_reset got=%b exp=%b", obs, {EN_STALL, 2'b10});
    end
    #1 reset = 1'b1;
    #1;
    tests++;
    if (obs !== {EN_RUN, 2'b00}) begin
      fails++; $display("FAIL async_reset got=%b exp=%b", obs, {EN_RUN, 2'b00});
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(0, 1, 0, 0, 0);
      tests++;
      if (obs !== {EN_RUN, 2'b00}) begin
        fails++; $display("FAIL post_reset c%0d got=%b exp=%b", i, obs, {EN_RUN, 2'b00});
      end
    end
    cyc(0, 0, 0, 0, 0);
    $display("[TB] reset_mid: busy op cleared asynchronously");
  endtask

`ifdef STALL_CNT_EN
  task automatic test_stall_cnt;
    logic [31:0] base;
    cyc(0, 0, 0, 0, 0);
    base = stall_cnt;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    tests++;
    if (stall_cnt !== base + 32'd3) begin
      fails++; $display("FAIL stall_cnt got=%0d exp=%0d", stall_cnt, base + 32'd3);
    end
    $display("[TB] stall_cnt: 4 hazard cycles, one under Req");
  endtask
`endif

  initial begin
    test_reset;
    test_mult_stall;
    test_div_mfhi;
    test_req_squash;
    test_req_busy;
    test_hazard;
    test_back_to_back;
    test_reset_mid;
`ifdef STALL_CNT_EN
    test_stall_cnt;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
